// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: hub FSM states, custom-insn opcode fields
// and the datapath width used across the coprocessor bus.
package pcpi_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] PCPI_OPCODE = 7'b0110011;
    localparam logic [6:0] PCPI_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } pcpi_state_e;

endpackage

// File: rtl/pcpi_resp_mux.sv
// Priority select of coprocessor responses (port 0 wins) and a flag
// for more than one port claiming completion in the same cycle.
import pcpi_pkg::*;

module pcpi_resp_mux #(
    parameter int NPORT = 2
) (
    input  logic [NPORT-1:0]      cp_wr,
    input  logic [XLEN*NPORT-1:0] cp_rd,
    input  logic [NPORT-1:0]      cp_ready,
    output logic                  any_ready,
    output logic                  sel_wr,
    output logic [XLEN-1:0]       sel_rd,
    output logic                  multi
);

    // Walk from the highest port down so the lowest ready index wins
    always_comb begin
        any_ready = |cp_ready;
        sel_wr    = 1'b0;
        sel_rd    = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (cp_ready[i]) begin
                sel_wr = cp_wr[i];
                sel_rd = cp_rd[i*XLEN +: XLEN];
            end
        end
        multi = (cp_ready & (cp_ready - NPORT'(1))) != '0;
    end

endmodule

// File: rtl/pcpi_hub.sv
// Dispatches one core request onto the PCPI bus, merges coprocessor
// responses into a single completion pulse and traps unclaimed insns.
import pcpi_pkg::*;

module pcpi_hub #(
    parameter int NPORT   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_valid,
    input  logic [XLEN-1:0]       cpu_insn,
    input  logic [XLEN-1:0]       cpu_rs1,
    input  logic [XLEN-1:0]       cpu_rs2,
    output logic                  cpu_done,
    output logic                  cpu_wr,
    output logic [XLEN-1:0]       cpu_rd,
    output logic                  cpu_trap,
    output logic                  cpu_conflict,
    output logic                  pcpi_valid,
    output logic [XLEN-1:0]       pcpi_insn,
    output logic [XLEN-1:0]       pcpi_rs1,
    output logic [XLEN-1:0]       pcpi_rs2,
    input  logic [NPORT-1:0]      cp_wr,
    input  logic [XLEN*NPORT-1:0] cp_rd,
    input  logic [NPORT-1:0]      cp_wait,
    input  logic [NPORT-1:0]      cp_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    pcpi_state_e     state;
    logic [CW-1:0]   cnt;
    logic            any_ready;
    logic            sel_wr;
    logic            multi;
    logic [XLEN-1:0] sel_rd;
    logic            take;

    pcpi_resp_mux #(
        .NPORT (NPORT)
    ) u_mux (
        .cp_wr     (cp_wr),
        .cp_rd     (cp_rd),
        .cp_ready  (cp_ready),
        .any_ready (any_ready),
        .sel_wr    (sel_wr),
        .sel_rd    (sel_rd),
        .multi     (multi)
    );

    // A ready only counts while a request is actually outstanding
    always_comb begin
        take = any_ready && (state == ISSUE || state == BUSY);
    end

    // Request sequencer: capture, claim tracking, timeout, completion
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            cpu_done     <= 1'b0;
            cpu_wr       <= 1'b0;
            cpu_rd       <= '0;
            cpu_trap     <= 1'b0;
            cpu_conflict <= 1'b0;
            pcpi_valid   <= 1'b0;
            pcpi_insn    <= '0;
            pcpi_rs1     <= '0;
            pcpi_rs2     <= '0;
        end else begin
            cpu_done     <= 1'b0;
            cpu_wr       <= 1'b0;
            cpu_trap     <= 1'b0;
            cpu_conflict <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        pcpi_valid <= 1'b1;
                        pcpi_insn  <= cpu_insn;
                        pcpi_rs1   <= cpu_rs1;
                        pcpi_rs2   <= cpu_rs2;
                        cnt        <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (any_ready) begin
                        state <= DONE;
                    end else if (|cp_wait) begin
                        state <= BUSY;
                    end else if (cnt == CNT_LAST) begin
                        state      <= DONE;
                        pcpi_valid <= 1'b0;
                        cpu_done   <= 1'b1;
                        cpu_trap   <= 1'b1;
                        cpu_rd     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BUSY: begin
                    if (any_ready) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (take) begin
                pcpi_valid   <= 1'b0;
                cpu_done     <= 1'b1;
                cpu_wr       <= sel_wr;
                cpu_rd       <= sel_rd;
                cpu_conflict <= multi;
            end
        end
    end

endmodule

// File: tb/tb_pcpi_hub.sv
// Directed bench for pcpi_hub: stimulus pushes expected completions,
// an independent monitor pops and checks them on every cpu_done.
module tb_pcpi_hub;
    import pcpi_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic        trap;
        logic        conf;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid;
    logic [31:0] cpu_insn, cpu_rs1, cpu_rs2;
    logic        cpu_done, cpu_wr, cpu_trap, cpu_conflict;
    logic [31:0] cpu_rd;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic [1:0]  cp_wr, cp_wait, cp_ready;
    logic [63:0] cp_rd;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    pcpi_hub #(.NPORT(2), .TIMEOUT(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_valid    (cpu_valid),
        .cpu_insn     (cpu_insn),
        .cpu_rs1      (cpu_rs1),
        .cpu_rs2      (cpu_rs2),
        .cpu_done     (cpu_done),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_trap     (cpu_trap),
        .cpu_conflict (cpu_conflict),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .cp_wr        (cp_wr),
        .cp_rd        (cp_rd),
        .cp_wait      (cp_wait),
        .cp_ready     (cp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [2:0] f3);
        return {PCPI_FUNCT7, 5'd2, 5'd1, f3, 5'd3, PCPI_OPCODE};
    endfunction

    // Present a request; returns at the first negedge in ISSUE
    task automatic start_req(input logic [31:0] insn,
                             input logic [31:0] a, input logic [31:0] b);
        cpu_valid = 1'b1;
        cpu_insn  = insn;
        cpu_rs1   = a;
        cpu_rs2   = b;
        tick();
        chk("accept_valid", {31'd0, pcpi_valid}, 32'd1);
    endtask

    task automatic clear_cp();
        cp_ready = '0;
        cp_wait  = '0;
        cp_wr    = '0;
        cp_rd    = '0;
    endtask

    // Completion monitor
    always @(negedge clk) begin
        if (cpu_done) begin
            n_done++;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got rd=%h trap=%b",
                         cpu_rd, cpu_trap);
            end else begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = '{cpu_wr, cpu_rd, cpu_trap, cpu_conflict};
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL completion: got wr=%b rd=%h trap=%b conf=%b expected wr=%b rd=%h trap=%b conf=%b",
                             a.wr, a.rd, a.trap, a.conf,
                             e.wr, e.rd, e.trap, e.conf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc;
        int d0;
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        cpu_insn  = '0;
        cpu_rs1   = '0;
        cpu_rs2   = '0;
        clear_cp();
        tick();
        tick();
        chk("rst_outs", {27'd0, cpu_done, cpu_wr, cpu_trap, cpu_conflict,
                         pcpi_valid}, 32'd0);
        chk("rst_rd", cpu_rd, 32'd0);
        chk("rst_insn", pcpi_insn, 32'd0);
        resetn = 1'b1;
        tick();

        // 1: DIVU 100/7 on port 1 with wait
        start_req(rtype(3'b101), 32'd100, 32'd7);
        chk("t1_rs1", pcpi_rs1, 32'd100);
        chk("t1_rs2", pcpi_rs2, 32'd7);
        tick();
        tick();
        cp_wait = 2'b10;
        repeat (3) tick();
        chk("t1_busy_hold", pcpi_insn, rtype(3'b101));
        cp_wait     = 2'b00;
        cp_ready    = 2'b10;
        cp_wr       = 2'b10;
        cp_rd       = {32'd14, 32'd0};
        q.push_back('{1'b1, 32'd14, 1'b0, 1'b0});
        tick();
        chk("t1_valid_low", {31'd0, pcpi_valid}, 32'd0);
        chk("t1_done", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_valid = 1'b0;
        tick();

        // 2: undefined insn, timeout trap
        q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
        start_req(32'h0000000B, 32'd5, 32'd6);
        vcyc = 1;
        while (pcpi_valid && vcyc < 40) begin
            tick();
            if (pcpi_valid) vcyc++;
        end
        chk("t2_valid_cycles", vcyc, 32'd16);
        chk("t2_done_edge", {31'd0, cpu_done}, 32'd1);
        cpu_valid = 1'b0;
        tick();

        // 3: zero-latency stub on port 0
        start_req(rtype(3'b000), 32'd1, 32'd2);
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd    = {32'd0, 32'hDEADBEEF};
        q.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
        tick();
        chk("t3_done_next", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_valid = 1'b0;
        tick();

        // 4: both ports ready together
        start_req(rtype(3'b001), 32'd3, 32'd4);
        tick();
        cp_ready = 2'b11;
        cp_wr    = 2'b11;
        cp_rd    = {32'h22222222, 32'h11111111};
        q.push_back('{1'b1, 32'h11111111, 1'b0, 1'b1});
        tick();
        chk("t4_done", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_valid = 1'b0;
        tick();

        // 5: reset mid-BUSY, then REM -7 % 2
        start_req(rtype(3'b101), 32'd50, 32'd3);
        tick();
        cp_wait = 2'b10;
        tick();
        tick();
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        tick();
        chk("t5_rst_outs", {27'd0, cpu_done, cpu_wr, cpu_trap, cpu_conflict,
                            pcpi_valid}, 32'd0);
        chk("t5_rst_rd", cpu_rd, 32'd0);
        resetn   = 1'b1;
        cp_wait  = 2'b00;
        d0       = n_done;
        cp_ready = 2'b10;
        cp_wr    = 2'b10;
        cp_rd    = {32'h12345678, 32'd0};
        tick();
        clear_cp();
        repeat (3) tick();
        chk("t5_no_done", n_done, d0);
        start_req(rtype(3'b110), 32'hFFFFFFF9, 32'd2);
        cp_wait = 2'b10;
        tick();
        cp_wait  = 2'b00;
        cp_ready = 2'b10;
        cp_wr    = 2'b10;
        cp_rd    = {32'hFFFFFFFF, 32'd0};
        q.push_back('{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0});
        tick();
        chk("t5_done", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_valid = 1'b0;
        tick();

        // 6: back-to-back requests
        d0 = n_done;
        start_req(rtype(3'b000), 32'd6, 32'd7);
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd    = {32'd0, 32'd42};
        q.push_back('{1'b1, 32'd42, 1'b0, 1'b0});
        tick();
        chk("t6a_done", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_insn = rtype(3'b100);
        cpu_rs1  = 32'd81;
        cpu_rs2  = 32'd9;
        tick();
        chk("t6_idle_gap", {31'd0, pcpi_valid}, 32'd0);
        tick();
        chk("t6b_accept", {31'd0, pcpi_valid}, 32'd1);
        chk("t6b_rs1", pcpi_rs1, 32'd81);
        cp_ready = 2'b10;
        cp_wr    = 2'b10;
        cp_rd    = {32'd9, 32'd0};
        q.push_back('{1'b1, 32'd9, 1'b0, 1'b0});
        tick();
        chk("t6b_done", {31'd0, cpu_done}, 32'd1);
        clear_cp();
        cpu_valid = 1'b0;
        repeat (3) tick();
        chk("t6_done_count", n_done - d0, 32'd2);
        chk("total_done", n_done, 32'd7);
        chk("queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcpi_hub.md
Name: pcpi_hub

Overview:
- Upstream dispatcher between the CPU core and the PCPI coprocessors (divider, multiplier, ...).
- Accepts one custom-instruction request from the core, latches it and broadcasts it on a registered PCPI bus to NPORT coprocessors.
- Merges their wait/ready/wr/rd responses into a single one-cycle completion to the core.
- Raises a trap when no coprocessor claims the instruction within TIMEOUT cycles.

Parameters:
- NPORT, 2, number of attached coprocessors; port 0 has highest priority.
- TIMEOUT, 16, cycles pcpi_valid may stay high with no cp_wait/cp_ready before a trap is raised; must be at least 2.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- cpu_valid  in  1  core request; held until cpu_done
- cpu_insn  in  32  instruction word
- cpu_rs1  in  32  operand 1
- cpu_rs2  in  32  operand 2
- cpu_done  out  1  one-cycle completion pulse
- cpu_wr  out  1  write-back enable; valid with cpu_done
- cpu_rd  out  32  result; valid with cpu_done
- cpu_trap  out  1  illegal-instruction flag; valid with cpu_done
- cpu_conflict  out  1  multiple-ready error flag; valid with cpu_done
- pcpi_valid  out  1  broadcast request to all coprocessors
- pcpi_insn  out  32  broadcast instruction
- pcpi_rs1  out  32  broadcast operand 1
- pcpi_rs2  out  32  broadcast operand 2
- cp_wr  in  NPORT  per-port write enable
- cp_rd  in  32*NPORT  per-port result; port i at bits [32i+31:32i]
- cp_wait  in  NPORT  per-port busy
- cp_ready  in  NPORT  per-port one-cycle done

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, timeout counter 0.
- Reset wins over every other event. If reset occurs mid-ISSUE/BUSY: the hub returns to IDLE, drops pcpi_valid the next cycle and gives no cpu_done. Any ready arriving later is ignored while in IDLE.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - When cpu_valid=1: latch insn/rs1/rs2 onto pcpi_*, set pcpi_valid=1, clear counter, go to ISSUE.
  - pcpi_insn/rs1/rs2 hold stable from this point until the hub returns to IDLE.
- ISSUE:
  - If any cp_ready: go to DONE, capturing the selected port.
  - Else if any cp_wait: go to BUSY.
  - Else if counter==TIMEOUT-1: go to DONE with trap.
  - Else counter+1.
  - Ready takes precedence over wait in the same cycle. A zero-wait coprocessor (ready with no prior wait) is legal.
- BUSY:
  - Waits for any cp_ready, with no time limit.
  - cp_wait dropping without ready keeps the hub in BUSY.
- Leaving ISSUE/BUSY toward DONE: pcpi_valid is cleared on the same edge that samples cp_ready. Coprocessors that gate on their own ready must therefore never see a second request.
- DONE (one cycle):
  - cpu_done=1.
  - On ready: cpu_wr=cp_wr[sel], cpu_rd=cp_rd[sel], where sel is the lowest-index port with ready.
  - On trap: cpu_trap=1, cpu_wr=0, cpu_rd=0.
  - cpu_conflict=1 if more than one cp_ready bit was set in the sampled cycle.
  - Next state is IDLE. cpu_done, cpu_wr, cpu_trap and cpu_conflict return to 0; cpu_rd holds.
- Core contract: cpu_valid drops in the cycle after cpu_done. If cpu_valid is still 1 in IDLE, it is accepted as a new request.
- Timing: trap case has pcpi_valid high for exactly TIMEOUT cycles; cpu_done/cpu_trap rise on the edge after that. Normal case has cpu_done exactly one cycle after the cycle in which cp_ready is high.
- Counter width: clog2(TIMEOUT+1).

Decomposition:
- Shared package pcpi_pkg:
  - state enum (IDLE/ISSUE/BUSY/DONE);
  - PCPI opcode constants (7'b0110011, funct7 7'b0000001);
  - XLEN=32.
- One sub-module, pcpi_resp_mux: combinational priority select of wr/rd over NPORT plus a multiple-ready flag. Everything else stays in the top.

Test Plan:
1. Divider on port 1, DIVU rs1=100 rs2=7:
   - cp_wait[1] rises 2 cycles after pcpi_valid;
   - after cp_ready[1], cpu_done=1, cpu_wr=1, cpu_rd=14;
   - pcpi_valid is low in the cycle after cp_ready.
2. Undefined insn 0x0000000B, no coprocessor responds:
   - pcpi_valid high 16 cycles;
   - then cpu_done=1, cpu_trap=1, cpu_wr=0, cpu_rd=0.
3. Zero-latency stub on port 0 asserts cp_ready with cp_rd=0xDEADBEEF in the first ISSUE cycle:
   - cpu_done next cycle, cpu_rd=0xDEADBEEF, no trap.
4. Ports 0 and 1 both assert ready in the same cycle (rd 0x11111111 / 0x22222222):
   - cpu_rd=0x11111111, cpu_conflict=1.
5. Divider claims with wait, then resetn=0 for 1 cycle mid-BUSY:
   - all outputs 0, no cpu_done;
   - a new REM rs1=-7 rs2=2 afterwards returns cpu_rd=0xFFFFFFFF.
6. Back-to-back requests with cpu_valid re-asserted the cycle after cpu_done:
   - second request accepted from IDLE;
   - both results correct, no lost or duplicate cpu_done.
